// File: rtl/cdb_broadcaster_if.sv
// Producer-side result handshake and broadcast CDB packet of the CDB transmitter.
// slave = the broadcaster; master = functional units and CDB snoopers.
`ifndef ROB_LEN
`define ROB_LEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_broadcaster_if #(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = $clog2(`ROB_LEN),
    parameter int XLEN       = `XLEN
);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [NUM_FU-1:0]                  fu_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]       fu_tag;
    logic [NUM_FU-1:0][XLEN-1:0]        fu_value;
    logic [NUM_FU-1:0]                  fu_ready;
    logic                               cdb_valid;
    logic [TAG_W-1:0]                   cdb_tag;
    logic [XLEN-1:0]                    cdb_value;
    logic [NUM_FU-1:0][OCC_W-1:0]       fu_occupancy;

    modport master (
        output fu_valid, fu_tag, fu_value,
        input  fu_ready, cdb_valid, cdb_tag, cdb_value, fu_occupancy
    );

    modport slave (
        input  fu_valid, fu_tag, fu_value,
        output fu_ready, cdb_valid, cdb_tag, cdb_value, fu_occupancy
    );
endinterface

// File: rtl/cdb_broadcaster.sv
// Purpose: per-FU result buffering plus round-robin pick driving the registered CDB packet.
// Latency: push edge, then CDB register edge -> broadcast two cycles after fu_valid, no bypass.
// Backpressure: fu_ready[i] is low while FIFO i is full, from registered occupancy only.
`ifndef ROB_LEN
`define ROB_LEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_result_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count,
    output logic             rdy,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign rdy      = (count != CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign head_dat = mem[rd_ptr];
    // A full buffer refuses a push even if it pops the same cycle: rdy never looks at pop.
    assign wr_en    = push && rdy && !flush;
    assign rd_en    = pop && !empty && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module cdb_broadcaster #(
    parameter int NUM_FU     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int TAG_W      = $clog2(`ROB_LEN),
    parameter int XLEN       = `XLEN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    cdb_broadcaster_if.slave  bus
);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  value;
    } cdb_entry_t;

    cdb_entry_t                 head [NUM_FU];
    logic [NUM_FU-1:0]          empty;
    logic [NUM_FU-1:0]          pop;
    logic [NUM_FU-1:0]          fu_ready_w;
    logic [NUM_FU-1:0][OCC_W-1:0] occ_w;
    logic [RR_W-1:0]            rr_ptr;
    logic [RR_W-1:0]            grant_idx;
    logic [RR_W-1:0]            cand;
    logic                       grant_vld;
    logic                       cdb_valid_q;
    logic [TAG_W-1:0]           cdb_tag_q;
    logic [XLEN-1:0]            cdb_value_q;

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
        cdb_result_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     ($bits(cdb_entry_t)),
            .CNT_W (OCC_W)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .flush    (squash),
            .push     (bus.fu_valid[gi]),
            .push_dat (cdb_entry_t'({bus.fu_tag[gi], bus.fu_value[gi]})),
            .pop      (pop[gi]),
            .head_dat (head[gi]),
            .count    (occ_w[gi]),
            .rdy      (fu_ready_w[gi]),
            .empty    (empty[gi])
        );
    end

    assign bus.fu_ready     = fu_ready_w;
    assign bus.fu_occupancy = occ_w;
    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_tag      = cdb_tag_q;
    assign bus.cdb_value    = cdb_value_q;

    // First non-empty head scanning upward from rr_ptr; nothing is granted while squashing.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (!squash) begin
            for (int k = 0; k < NUM_FU; k++) begin
                cand = RR_W'((int'(rr_ptr) + k) % NUM_FU);
                if (!grant_vld && !empty[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_vld) pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else if (squash) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else if (grant_vld) begin
            rr_ptr      <= RR_W'((int'(grant_idx) + 1) % NUM_FU);
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= head[grant_idx].tag;
            cdb_value_q <= head[grant_idx].value;
        end else begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end
    end

    // Producer protocol check: a push into a full buffer is dropped by the FIFO.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                assert (!(bus.fu_valid[i] && !fu_ready_w[i]))
                    else $warning("cdb_broadcaster: FU %0d pushed while its buffer was full, result dropped", i);
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: hand-traced vectors per scenario, inline checks.
module tb_cdb_broadcaster;
    logic clock;
    logic reset;
    logic squash;
    int   errors = 0;
    int   checks = 0;

    cdb_broadcaster_if #(.NUM_FU(4), .FIFO_DEPTH(2), .TAG_W(5), .XLEN(32)) bus ();

    cdb_broadcaster #(.NUM_FU(4), .FIFO_DEPTH(2), .TAG_W(5), .XLEN(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic clear_inputs;
        bus.fu_valid = '0;
        bus.fu_tag   = '0;
        bus.fu_value = '0;
    endtask

    task automatic push(input int fu, input logic [4:0] tag, input logic [31:0] val);
        bus.fu_valid[fu] = 1'b1;
        bus.fu_tag[fu]   = tag;
        bus.fu_value[fu] = val;
    endtask

    task automatic do_squash;
        squash = 1'b1;
        tick;
        squash = 1'b0;
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        squash = 1'b0;
        bus.fu_valid = 4'b1111;
        bus.fu_tag   = {5'd1, 5'd2, 5'd3, 5'd4};
        bus.fu_value = {32'h1, 32'h2, 32'h3, 32'h4};
        repeat (2) tick;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.cdb_valid); end
        checks++; if (bus.fu_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready: got %b want 1111", bus.fu_ready); end
        checks++; if (bus.fu_occupancy !== 8'h00) begin errors++; $display("FAIL reset_occ: got %h want 00", bus.fu_occupancy); end
        checks++; if (bus.cdb_tag !== 5'd0 || bus.cdb_value !== 32'd0) begin errors++; $display("FAIL reset_pkt: got %h/%h want 0/0", bus.cdb_tag, bus.cdb_value); end
        clear_inputs;
        reset = 1'b1;
        tick;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_single;
        push(1, 5'd5, 32'hDEAD_BEEF);
        tick;
        clear_inputs;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", bus.cdb_valid); end
        checks++; if (bus.fu_occupancy[1] !== 2'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", bus.fu_occupancy[1]); end
        checks++; if (bus.fu_ready[1] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", bus.fu_ready[1]); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 5'd5 || bus.cdb_value !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL single_bcast: got v=%b t=%0d d=%h want v=1 t=5 d=deadbeef", bus.cdb_valid, bus.cdb_tag, bus.cdb_value); end
        checks++; if (bus.fu_occupancy[1] !== 2'd0) begin errors++; $display("FAIL single_pop: got %0d want 0", bus.fu_occupancy[1]); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_tag_zero;
        logic rs_wakeup;
        push(3, 5'd0, 32'h0000_0001);
        tick;
        clear_inputs;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL tag0_early: got %b want 0", bus.cdb_valid); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 5'd0 || bus.cdb_value !== 32'd1) begin
            errors++; $display("FAIL tag0_bcast: got v=%b t=%0d d=%h want v=1 t=0 d=1", bus.cdb_valid, bus.cdb_tag, bus.cdb_value); end
        rs_wakeup = bus.cdb_valid && (bus.cdb_tag == 5'd0);
        checks++; if (rs_wakeup !== 1'b1) begin errors++; $display("FAIL tag0_rs_capture: got %b want 1", rs_wakeup); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b0 || bus.cdb_value !== 32'd0) begin
            errors++; $display("FAIL tag0_idle: got v=%b d=%h want v=0 d=0", bus.cdb_valid, bus.cdb_value); end
    endtask

    task automatic test_contention;
        logic [4:0] exp_tag [3];
        exp_tag[0] = 5'd1; exp_tag[1] = 5'd2; exp_tag[2] = 5'd3;
        do_squash;
        push(0, 5'd1, 32'h11);
        push(2, 5'd2, 32'h22);
        push(3, 5'd3, 32'h33);
        tick;
        clear_inputs;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL cont_early: got %b want 0", bus.cdb_valid); end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== exp_tag[i]) begin
                errors++; $display("FAIL cont_order%0d: got v=%b t=%0d want v=1 t=%0d", i, bus.cdb_valid, bus.cdb_tag, exp_tag[i]); end
        end
        // rr_ptr should be back at 0, so FU0 beats FU1
        push(0, 5'd10, 32'hA0);
        push(1, 5'd11, 32'hB0);
        tick;
        clear_inputs;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL cont_gap: got %b want 0", bus.cdb_valid); end
        tick;
        checks++; if (bus.cdb_tag !== 5'd10 || bus.cdb_valid !== 1'b1) begin errors++; $display("FAIL cont_rr_wrap0: got t=%0d want 10", bus.cdb_tag); end
        tick;
        checks++; if (bus.cdb_tag !== 5'd11 || bus.cdb_valid !== 1'b1) begin errors++; $display("FAIL cont_rr_wrap1: got t=%0d want 11", bus.cdb_tag); end
        tick;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL cont_idle: got %b want 0", bus.cdb_valid); end
    endtask

    task automatic test_backpressure;
        logic [4:0] exp_tag [4];
        exp_tag[0] = 5'd7; exp_tag[1] = 5'd21; exp_tag[2] = 5'd8; exp_tag[3] = 5'd22;
        do_squash;
        push(0, 5'd30, 32'h300);
        push(1, 5'd20, 32'h200);
        tick;
        clear_inputs;
        push(0, 5'd7, 32'h70);
        push(1, 5'd21, 32'h210);
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_early: got %b want 0", bus.cdb_valid); end
        tick;
        clear_inputs;
        push(0, 5'd8, 32'h80);
        checks++; if (bus.cdb_tag !== 5'd30) begin errors++; $display("FAIL bp_primer: got t=%0d want 30", bus.cdb_tag); end
        tick;
        clear_inputs;
        checks++; if (bus.fu_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", bus.fu_ready[0]); end
        checks++; if (bus.fu_occupancy[0] !== 2'd2) begin errors++; $display("FAIL bp_full_occ: got %0d want 2", bus.fu_occupancy[0]); end
        checks++; if (bus.cdb_tag !== 5'd20) begin errors++; $display("FAIL bp_fu1: got t=%0d want 20", bus.cdb_tag); end
        push(0, 5'd9, 32'h90);
        push(1, 5'd22, 32'h220);
        tick;
        clear_inputs;
        checks++; if (bus.fu_occupancy[0] !== 2'd1) begin errors++; $display("FAIL bp_drop_occ: got %0d want 1", bus.fu_occupancy[0]); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick;
            checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== exp_tag[i]) begin
                errors++; $display("FAIL bp_order%0d: got v=%b t=%0d want v=1 t=%0d", i, bus.cdb_valid, bus.cdb_tag, exp_tag[i]); end
        end
        tick;
        checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_tag9_dropped: got v=%b t=%0d want v=0", bus.cdb_valid, bus.cdb_tag); end
    endtask

    task automatic test_squash;
        push(0, 5'd14, 32'h140);
        push(1, 5'd24, 32'h240);
        tick;
        push(0, 5'd15, 32'h150);
        push(1, 5'd25, 32'h250);
        tick;
        clear_inputs;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 5'd14) begin
            errors++; $display("FAIL sq_pre: got v=%b t=%0d want v=1 t=14", bus.cdb_valid, bus.cdb_tag); end
        push(2, 5'd4, 32'h44);
        squash = 1'b1;
        tick;
        squash = 1'b0;
        clear_inputs;
        checks++; if (bus.cdb_valid !== 1'b0 || bus.cdb_tag !== 5'd0) begin
            errors++; $display("FAIL sq_pkt: got v=%b t=%0d want v=0 t=0", bus.cdb_valid, bus.cdb_tag); end
        checks++; if (bus.fu_occupancy !== 8'h00) begin errors++; $display("FAIL sq_occ: got %h want 00", bus.fu_occupancy); end
        checks++; if (bus.fu_ready !== 4'b1111) begin errors++; $display("FAIL sq_ready: got %b want 1111", bus.fu_ready); end
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL sq_quiet%0d: got v=%b t=%0d want v=0", i, bus.cdb_valid, bus.cdb_tag); end
        end
    endtask

    task automatic test_async_reset;
        push(0, 5'd12, 32'hC);
        push(2, 5'd6, 32'h66);
        tick;
        clear_inputs;
        tick;
        checks++; if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== 5'd12) begin
            errors++; $display("FAIL ar_pre: got v=%b t=%0d want v=1 t=12", bus.cdb_valid, bus.cdb_tag); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.cdb_valid !== 1'b0 || bus.cdb_value !== 32'd0) begin
            errors++; $display("FAIL ar_async_pkt: got v=%b d=%h want v=0 d=0", bus.cdb_valid, bus.cdb_value); end
        checks++; if (bus.fu_occupancy !== 8'h00) begin errors++; $display("FAIL ar_occ: got %h want 00", bus.fu_occupancy); end
        tick;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus.cdb_valid !== 1'b0) begin errors++; $display("FAIL ar_no_survivor%0d: got v=%b t=%0d want v=0", i, bus.cdb_valid, bus.cdb_tag); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_tag_zero;
        test_contention;
        test_backpressure;
        test_squash;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
Transmit end of the common data bus. Each functional unit (ALU, MULT, LSQ, BRANCH) hands over completed results as a (ROB tag, value) pair. The block buffers each unit's results in a small per-unit FIFO and picks one result per cycle with a round-robin arbiter. It drives the registered CDB packet that every RS entry, the map table and the ROB snoop.

Parameters:
NUM_FU, 4, number of functional-unit producers
FIFO_DEPTH, 2, result buffer entries per FU (power of 2, >=2)
TAG_W, $clog2(`ROB_LEN), ROB tag width
XLEN, `XLEN, result value width

Ports:
clock  input  1  single system clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 = in reset); deassertion is synchronised externally
squash  input  1  synchronous flush from branch recovery
fu_valid  input  NUM_FU  per-FU result-valid strobe
fu_tag  input  NUM_FU x TAG_W  ROB entry of each result
fu_value  input  NUM_FU x XLEN  result data
fu_ready  output  NUM_FU  FIFO of that FU can accept a push this cycle
cdb_valid  output  1  CDB packet valid (reg_tag.valid)
cdb_tag  output  TAG_W  broadcast ROB tag (reg_tag.tag)
cdb_value  output  XLEN  broadcast value (reg_value)
fu_occupancy  output  NUM_FU x $clog2(FIFO_DEPTH+1)  entries held per FIFO (debug/perf)

Behaviour:
- Reset (reset==0, async): all FIFOs empty; rd/wr pointers 0; round-robin pointer 0; cdb_valid=0, cdb_tag=0, cdb_value=0; fu_ready all 1; fu_occupancy 0.
- fu_ready[i] = (occupancy[i] < FIFO_DEPTH). It is computed from registered state only. There is no combinational path from fu_valid or the grant to fu_ready.
- Push: fu_valid[i] && fu_ready[i] at a posedge writes {tag, value} into FIFO i. fu_valid[i] while fu_ready[i]==0 is a producer protocol error. The data is dropped and a simulation assertion fires.
- Arbitration (combinational, each cycle): the candidates are the non-empty FIFO heads. The grant goes to the first non-empty index scanning from rr_ptr upward, modulo NUM_FU. No candidates means no grant.
- On a grant g at a posedge:
  - FIFO g pops.
  - rr_ptr <= (g+1) mod NUM_FU.
  - cdb_valid<=1, cdb_tag<=head.tag, cdb_value<=head.value.
- With no grant: cdb_valid<=0, cdb_tag<=0, cdb_value<=0, and rr_ptr holds. Consumers qualify on valid, so tag 0 with cdb_valid=1 is a legal broadcast of ROB entry 0.
- Latency: a push in cycle C broadcasts in cycle C+2 at the earliest (FIFO write edge, then CDB register edge). There is no bypass.
- Throughput: exactly one broadcast per cycle while any FIFO is non-empty.
- Simultaneous push and pop on the same FIFO: both take effect and occupancy is unchanged. This is legal even when the FIFO is full only if fu_ready was 1. Since fu_ready ignores the same-cycle pop, a full FIFO never takes a push.
- Pointer wrap: rd/wr pointers wrap modulo FIFO_DEPTH. Occupancy is a separate counter so that full and empty are distinguishable.
- Squash (sync, evaluated at posedge):
  - All FIFOs are emptied, rr_ptr<=0, cdb_valid<=0, cdb_tag<=0, cdb_value<=0.
  - A push in the squash cycle is dropped.
  - No grant is made in the squash cycle.
- Reset asserted mid-broadcast: cdb_valid drops immediately (async). No FIFO content survives.
- Ordering: results from the same FU broadcast in push order. There is no ordering guarantee across FUs beyond round-robin fairness. Every non-empty FIFO is granted within NUM_FU cycles.

Test Plan:
- Reset: hold reset=0 with fu_valid=4'b1111 -> cdb_valid=0, fu_ready=4'b1111, occupancy all 0; the first cycle after release shows no broadcast.
- Single result: FU1 pushes tag=5, value=32'hDEAD_BEEF in cycle 3 -> cycle 5 shows cdb_valid=1, tag=5, value=32'hDEADBEEF; cycle 6 shows cdb_valid=0.
- Contention: FU0, FU2 and FU3 push tags 1, 2 and 3 in the same cycle with rr_ptr=0 -> broadcasts on three consecutive cycles in order tag 1, 2, 3; rr_ptr then equals 0.
- Backpressure: FU0 pushes tags 7, 8 and 9 on back-to-back cycles while FU1 is granted continuously -> fu_ready[0] is 0 after two pushes, tag 9 push flags an assertion, FU0 broadcasts are tag 7 then 8, order preserved.
- Squash: load FU0 and FU1 with two entries each, assert squash for one cycle while FU2 pushes tag 4 -> next cycle cdb_valid=0, all occupancies 0, tag 4 is never broadcast.
- Tag zero: FU3 pushes tag=0, value=32'h0000_0001 -> cdb_valid=1, cdb_tag=0, cdb_value=1 two cycles later; an RS entry waiting on tag 0 with valid=1 must capture it.
